// File: rtl/ram_loader_if.sv
// Byte-stream handshake from the host plus the programming port into the program RAM.
// master: the host/upstream side; slave: the loader that consumes bytes and drives the RAM.
interface ram_loader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  prg_mode;
  logic [ADDR_WIDTH-1:0] prg_address;
  logic [DATA_WIDTH-1:0] prg_data;
  logic                  prg_wr;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  prg_mode,
    input  prg_address,
    input  prg_data,
    input  prg_wr
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output prg_mode,
    output prg_address,
    output prg_data,
    output prg_wr
  );
endinterface

// File: rtl/ram_loader.sv
// Program loader: takes bytes over valid/ready and writes them into the program RAM from
// START_ADDR upward, keeping a byte count, a running checksum and a sticky loaded flag.
module ram_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LOAD_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  ram_loader_if.slave           bus,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH + 1)'(LOAD_LEN);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  loaded_q, loaded_d;
  logic [ADDR_WIDTH:0]   count_inc;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    sum_d    = sum_q;
    loaded_d = loaded_q;
    case (state_q)
      IDLE: begin
        // start beats a simultaneous abort; abort alone is a no-op here
        if (start) begin
          state_d  = LOAD;
          addr_d   = FIRST_ADDR;
          count_d  = '0;
          sum_d    = '0;
          loaded_d = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bus.in_valid) begin
          data_d  = bus.in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // the strobe in this cycle always lands, so it is counted even when aborting
        count_d = count_inc;
        sum_d   = sum_q + data_q;
        if (abort) begin
          state_d = IDLE;
        end else if (count_inc == LAST_COUNT) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= FIRST_ADDR;
      data_q   <= '0;
      count_q  <= '0;
      sum_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      loaded_q <= loaded_d;
    end
  end

  // Everything below decodes registered state, so reset clears it without waiting for a clock.
  assign bus.in_ready    = (state_q == LOAD);
  assign bus.prg_mode    = (state_q != IDLE);
  assign bus.prg_wr      = (state_q == WRITE);
  assign bus.prg_address = addr_q;
  assign bus.prg_data    = data_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign loaded          = loaded_q;
  assign byte_count      = count_q;
  assign checksum        = sum_q;

endmodule
